wb_group_arbiter: RTL

- Shares one writeback group port between NUM_UNITS multicycle execution units.
- Each unit holds a completed result (ID + rd data) until it is granted. The arbiter picks one per cycle by round-robin and registers it into a single-entry output stage.
- The output stage drives the wb_packet fields consumed by ID/metadata management, which does commit phys-addr lookup and toggles the waiting-for-writeback bit.
- A downstream stall holds the output stage. A flush drops it.

---
 rtl/wb_group_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/wb_group_arbiter.sv
// Round-robin arbiter sharing one writeback port between NUM_UNITS multicycle units.
// The winner is captured into a single-entry output stage that honours stall and flush.
module wb_group_arbiter #(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_UNITS-1:0]           unit_done,
  input  logic [NUM_UNITS*ID_W-1:0]      unit_id,
  input  logic [NUM_UNITS*DATA_W-1:0]    unit_rd,
  output logic [NUM_UNITS-1:0]           unit_ack,
  input  logic                           wb_stall,
  output logic                           wb_valid,
  output logic [ID_W-1:0]                wb_id,
  output logic [DATA_W-1:0]              wb_data,
  output logic [$clog2(NUM_UNITS)-1:0]   wb_unit
);

  localparam int unsigned UW = $clog2(NUM_UNITS);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [UW-1:0]     rr_ptr;
  logic [UW-1:0]     winner;
  logic [UW-1:0]     ptr_nxt;
  logic              found;
  logic              can_load;
  logic              grant;
  int unsigned       scan_idx;
  logic [ID_W-1:0]   sel_id;
  logic [DATA_W-1:0] sel_rd;

  // Circular scan starting at rr_ptr; first requester found wins.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = 0;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      scan_idx = 32'(rr_ptr) + k;
      if (scan_idx >= NUM_UNITS) scan_idx = scan_idx - NUM_UNITS;
      if (!found && unit_done[UW'(scan_idx)]) begin
        found  = 1'b1;
        winner = UW'(scan_idx);
      end
    end
  end

  assign can_load = (state == EMPTY) || !wb_stall;
  assign grant    = rst && !flush && can_load && found;
  assign ptr_nxt  = (winner == UW'(NUM_UNITS - 1)) ? '0 : winner + UW'(1);

  always_comb begin
    unit_ack = '0;
    if (grant) unit_ack[winner] = 1'b1;
  end

  // Payload mux for the winning unit.
  always_comb begin
    sel_id = '0;
    sel_rd = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (UW'(i) == winner) begin
        sel_id = unit_id[i*ID_W +: ID_W];
        sel_rd = unit_rd[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output-stage state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  // Flush beats everything; a grant refills; an unstalled full stage drains.
  always_comb begin
    state_nxt = state;
    if (flush)                              state_nxt = EMPTY;
    else if (grant)                         state_nxt = FULL;
    else if ((state == FULL) && !wb_stall)  state_nxt = EMPTY;
  end

  always_comb begin
    wb_valid = (state == FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_id   <= '0;
      wb_data <= '0;
      wb_unit <= '0;
      rr_ptr  <= '0;
    end else if (grant) begin
      wb_id   <= sel_id;
      wb_data <= sel_rd;
      wb_unit <= winner;
      rr_ptr  <= ptr_nxt;
    end
  end

  a_ack_onehot : assert property (@(posedge clk) $onehot0(unit_ack));
  a_ack_done   : assert property (@(posedge clk) (unit_ack & ~unit_done) == '0);
  a_stall_hold : assert property (@(posedge clk) disable iff (!rst)
                   (wb_valid && wb_stall && !flush) |=>
                   (wb_valid && $stable(wb_id) && $stable(wb_data) && $stable(wb_unit)));

endmodule
